// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit segment per stage,
// valid/ready handshake with a global stall when the output is not taken.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("cla_pipe_adder: WIDTH must be an integer multiple of SEG");
  end

  // Flat sum-of-products lookahead: every carry is formed directly from the
  // segment carry-in and the per-bit generate/propagate terms.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic ci);
    logic [SEG-1:0] g, p, s;
    logic [SEG:0]   c;
    logic           run;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      run = 1'b1;
      c[i+1] = 1'b0;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (run & g[j]);
        run    = run & p[j];
      end
      c[i+1] = c[i+1] | (run & ci);
    end
    s = p ^ c[SEG-1:0];
    return {c[SEG], s};
  endfunction

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             ovf_q;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub | cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN  = WIDTH - k * SEG;
    localparam int REM = IN - SEG;
    localparam int ACC = (k + 1) * SEG;

    logic            vld_in, c_in;
    logic [IN-1:0]   a_in, b_in;
    logic [SEG:0]    seg;
    logic            vld_q, c_q;
    logic [ACC-1:0]  s_q;

    assign seg = cla_seg(a_in[SEG-1:0], b_in[SEG-1:0], c_in);

    if (k == 0) begin : g_head
      assign vld_in = in_valid;
      assign c_in   = cin_eff;
      assign a_in   = a;
      assign b_in   = b_eff;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)         s_q <= '0;
        else if (!stall) s_q <= seg[SEG-1:0];
      end
    end else begin : g_head
      assign vld_in = g_stage[k-1].vld_q;
      assign c_in   = g_stage[k-1].c_q;
      assign a_in   = g_stage[k-1].g_rem.a_q;
      assign b_in   = g_stage[k-1].g_rem.b_q;

      // completed segments accumulate below the one finished here
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         s_q <= '0;
        else if (!stall) s_q <= {seg[SEG-1:0], g_stage[k-1].s_q};
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
      end else if (!stall) begin
        vld_q <= vld_in;
        c_q   <= seg[SEG];
      end
    end

    if (REM > 0) begin : g_rem
      logic [REM-1:0] a_q, b_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_in[IN-1:SEG];
          b_q <= b_in[IN-1:SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_ovf
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          ovf_q <= 1'b0;
        else if (!stall)
          ovf_q <= (a_in[SEG-1] == b_in[SEG-1]) & (seg[SEG-1] != a_in[SEG-1]);
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = ovf_q;

endmodule
